// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter over open-drain PS2Clk/PS2Data.
// Optional macro PS2_TX_RETRY_EN: one automatic retry after a NACK or timeout.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES    = 10000,
  parameter int START_HOLD_CYCLES = 200,
  parameter int TIMEOUT_CYCLES    = 2000000
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [7:0] i_data,
  input  logic       i_valid,
  output logic       o_ready,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_nack,
  output logic       o_timeout,
  input  logic       i_ps2_clk,
  input  logic       i_ps2_data,
  output logic       o_ps2_clk_oe,
  output logic       o_ps2_data_oe
);

  localparam int HOLD_MAX = (INHIBIT_CYCLES > START_HOLD_CYCLES) ? INHIBIT_CYCLES : START_HOLD_CYCLES;
  localparam int HOLD_W   = $clog2(HOLD_MAX + 1);
  localparam int TO_W     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [HOLD_W-1:0] INHIBIT_LAST = HOLD_W'(INHIBIT_CYCLES - 1);
  localparam logic [HOLD_W-1:0] START_LAST   = HOLD_W'(START_HOLD_CYCLES - 1);
  localparam logic [TO_W-1:0]   TO_LAST      = TO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_START,
    S_BITS,
    S_WAIT_IDLE,
    S_DONE
  } state_t;

  state_t             state, state_n;
  logic [HOLD_W-1:0]  hold_cnt, hold_n;
  logic [TO_W-1:0]    to_cnt, to_n;
  logic [3:0]         bit_cnt, bit_n;
  logic               clk_oe, clk_oe_n;
  logic               data_oe, data_oe_n;
  logic               nack, nack_n;
  logic               timeout, timeout_n;
  logic               nack_pend, nack_pend_n;
  logic               load;
  logic               fail_nack, fail_to;
  logic [7:0]         tx_byte;
  logic               tx_parity;
  logic               clk_p0, clk_p1, clk_p2;
  logic               dat_p0, dat_p1;
  logic               clk_fall, clk_edge, to_expired;
`ifdef PS2_TX_RETRY_EN
  logic               retried, retried_n;
`endif

  function automatic logic frame_bit(input logic [7:0] d, input logic p, input logic [3:0] idx);
    if (idx < 4'd8)
      frame_bit = d[idx[2:0]];
    else if (idx == 4'd8)
      frame_bit = p;
    else
      frame_bit = 1'b1;
  endfunction

  assign clk_fall   = clk_p2 & ~clk_p1;
  assign clk_edge   = clk_p2 ^ clk_p1;
  assign to_expired = (to_cnt == TO_LAST);

  always_comb begin
    state_n     = state;
    hold_n      = hold_cnt;
    bit_n       = bit_cnt;
    data_oe_n   = data_oe;
    nack_n      = nack;
    timeout_n   = timeout;
    nack_pend_n = nack_pend;
    load        = 1'b0;
    fail_nack   = 1'b0;
    fail_to     = 1'b0;
`ifdef PS2_TX_RETRY_EN
    retried_n   = retried;
`endif
    case (state)
      S_IDLE: begin
        data_oe_n = 1'b0;
        if (i_valid) begin
          load        = 1'b1;
          state_n     = S_INHIBIT;
          hold_n      = '0;
          nack_n      = 1'b0;
          timeout_n   = 1'b0;
          nack_pend_n = 1'b0;
`ifdef PS2_TX_RETRY_EN
          retried_n   = 1'b0;
`endif
        end
      end
      S_INHIBIT: begin
        data_oe_n = 1'b0;
        if (hold_cnt == INHIBIT_LAST) begin
          state_n   = S_START;
          hold_n    = '0;
          data_oe_n = 1'b1;
        end else begin
          hold_n = hold_cnt + 1'b1;
        end
      end
      S_START: begin
        data_oe_n = 1'b1;
        if (hold_cnt == START_LAST) begin
          state_n = S_BITS;
          bit_n   = '0;
        end else begin
          hold_n = hold_cnt + 1'b1;
        end
      end
      S_BITS: begin
        // The device clocks the frame; the host only updates data on its falls.
        if (clk_fall) begin
          if (bit_cnt == 4'd10) begin
            nack_pend_n = dat_p1;
            state_n     = S_WAIT_IDLE;
          end else begin
            data_oe_n = ~frame_bit(tx_byte, tx_parity, bit_cnt);
            bit_n     = bit_cnt + 4'd1;
          end
        end else if (to_expired) begin
          fail_to = 1'b1;
        end
      end
      S_WAIT_IDLE: begin
        data_oe_n = 1'b0;
        if (clk_p1 && dat_p1) begin
          if (nack_pend) begin
            fail_nack = 1'b1;
          end else begin
            state_n   = S_DONE;
            nack_n    = 1'b0;
            timeout_n = 1'b0;
          end
        end else if (to_expired) begin
          fail_to = 1'b1;
        end
      end
      S_DONE: begin
        state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase

    if (fail_nack || fail_to) begin
      data_oe_n = 1'b0;
      hold_n    = '0;
`ifdef PS2_TX_RETRY_EN
      if (!retried) begin
        state_n   = S_INHIBIT;
        retried_n = 1'b1;
      end else begin
        state_n   = S_DONE;
        nack_n    = fail_nack;
        timeout_n = fail_to;
      end
`else
      state_n   = S_DONE;
      nack_n    = fail_nack;
      timeout_n = fail_to;
`endif
    end

    // Any synchronized clock edge or state change restarts the watchdog.
    if ((state_n != state) || clk_edge)
      to_n = '0;
    else if ((state == S_BITS) || (state == S_WAIT_IDLE))
      to_n = to_cnt + 1'b1;
    else
      to_n = to_cnt;

    clk_oe_n = (state_n == S_INHIBIT) || (state_n == S_START);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= S_IDLE;
      hold_cnt  <= '0;
      to_cnt    <= '0;
      bit_cnt   <= '0;
      clk_oe    <= 1'b0;
      data_oe   <= 1'b0;
      nack      <= 1'b0;
      timeout   <= 1'b0;
      nack_pend <= 1'b0;
      clk_p0    <= 1'b1;
      clk_p1    <= 1'b1;
      clk_p2    <= 1'b1;
      dat_p0    <= 1'b1;
      dat_p1    <= 1'b1;
`ifdef PS2_TX_RETRY_EN
      retried   <= 1'b0;
`endif
    end else begin
      state     <= state_n;
      hold_cnt  <= hold_n;
      to_cnt    <= to_n;
      bit_cnt   <= bit_n;
      clk_oe    <= clk_oe_n;
      data_oe   <= data_oe_n;
      nack      <= nack_n;
      timeout   <= timeout_n;
      nack_pend <= nack_pend_n;
      clk_p0    <= i_ps2_clk;
      clk_p1    <= clk_p0;
      clk_p2    <= clk_p1;
      dat_p0    <= i_ps2_data;
      dat_p1    <= dat_p0;
`ifdef PS2_TX_RETRY_EN
      retried   <= retried_n;
`endif
    end
  end

  always_ff @(posedge i_clk) begin
    if (load) begin
      tx_byte   <= i_data;
      tx_parity <= ~^i_data;
    end
  end

  assign o_ready       = (state == S_IDLE);
  assign o_busy        = (state != S_IDLE);
  assign o_done        = (state == S_DONE);
  assign o_nack        = nack;
  assign o_timeout     = timeout;
  assign o_ps2_clk_oe  = clk_oe;
  assign o_ps2_data_oe = data_oe;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: table of command bytes sent to a behavioural PS/2 device.
`timescale 1ns/1ps
module tb_ps2_host_tx;

  localparam int INH  = 20;
  localparam int STH  = 10;
  localparam int TOC  = 400;
  localparam int HALF = 30;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] data = 8'h00;
  logic       valid = 1'b0;
  logic       ready, busy, done, nack, timeout;
  logic       clk_oe, data_oe;
  logic       dev_clk = 1'b1;
  logic       dev_data = 1'b1;
  logic       ps2_clk, ps2_data;

  assign ps2_clk  = ~clk_oe & dev_clk;
  assign ps2_data = ~data_oe & dev_data;

  always #5 clk = ~clk;

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .START_HOLD_CYCLES(STH),
    .TIMEOUT_CYCLES(TOC)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .i_data(data),
    .i_valid(valid),
    .o_ready(ready),
    .o_busy(busy),
    .o_done(done),
    .o_nack(nack),
    .o_timeout(timeout),
    .i_ps2_clk(ps2_clk),
    .i_ps2_data(ps2_data),
    .o_ps2_clk_oe(clk_oe),
    .o_ps2_data_oe(data_oe)
  );

  int   checks = 0;
  int   errors = 0;
  int   done_cnt = 0;
  logic nack_seen = 1'b0;
  logic to_seen = 1'b0;

  always @(negedge clk) begin
    if (done === 1'b1) begin
      done_cnt  <= done_cnt + 1;
      nack_seen <= nack;
      to_seen   <= timeout;
    end
  end

  typedef struct {
    logic [7:0] data;
    bit         ack;
    logic       par;
    logic       exp_nack;
  } vec_t;

  vec_t vecs [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic request(input logic [7:0] d);
    @(negedge clk);
    data  = d;
    valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
  endtask

  task automatic wait_host_release(input string name);
    int n;
    n = 0;
    while (clk_oe !== 1'b1 && n < INH + 10) begin tick(1); n++; end
    check({name, "_inhibit"}, clk_oe, 1'b1);
    n = 0;
    while (clk_oe !== 1'b0 && n < INH + STH + 10) begin tick(1); n++; end
    check({name, "_release"}, clk_oe, 1'b0);
    check({name, "_start_bit"}, data_oe, 1'b1);
  endtask

  task automatic device_frame(input bit ack, output logic [9:0] cap);
    cap = '0;
    tick(20);
    for (int k = 0; k < 11; k++) begin
      if (k == 10 && ack) dev_data = 1'b0;
      tick(5);
      dev_clk = 1'b0;
      tick(HALF);
      dev_clk = 1'b1;
      if (k < 10) cap[k] = ps2_data;
      tick(HALF);
    end
    dev_data = 1'b1;
  endtask

  task automatic wait_done(input int start, input int budget, input string name);
    int n;
    n = 0;
    while (done_cnt == start && n < budget) begin tick(1); n++; end
    check({name, "_done_count"}, done_cnt, start + 1);
  endtask

  task automatic check_frame(input string name, input logic [9:0] cap, input logic [7:0] d, input logic p);
    check({name, "_bits"}, cap[7:0], d);
    check({name, "_parity"}, cap[8], p);
    check({name, "_stop"}, cap[9], 1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, errors %0d", errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [9:0] cap;
    logic       exp_nack;
    int         st;

    vecs[0] = '{8'hED, 1'b1, 1'b1, 1'b0};
    vecs[1] = '{8'hF4, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{8'h00, 1'b1, 1'b1, 1'b0};
    vecs[3] = '{8'hFF, 1'b0, 1'b1, 1'b1};
    vecs[4] = '{8'h01, 1'b1, 1'b0, 1'b0};

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_clk_oe", clk_oe, 1'b0);
    check("rst_data_oe", data_oe, 1'b0);
    check("rst_ready", ready, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_nack", nack, 1'b0);
    check("rst_timeout", timeout, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    tick(3);

    for (int i = 0; i < 5; i++) begin
      st = done_cnt;
      request(vecs[i].data);
      check($sformatf("v%0d_busy", i), busy, 1'b1);
      check($sformatf("v%0d_ready_low", i), ready, 1'b0);
      if (i == 1) begin
        tick(5);
        data  = 8'hAA;
        valid = 1'b1;
        tick(1);
        valid = 1'b0;
      end
      wait_host_release($sformatf("v%0d", i));
      device_frame(vecs[i].ack, cap);
      check_frame($sformatf("v%0d", i), cap, vecs[i].data, vecs[i].par);
      exp_nack = vecs[i].exp_nack;
`ifdef PS2_TX_RETRY_EN
      if (!vecs[i].ack) begin
        wait_host_release($sformatf("v%0d_retry", i));
        device_frame(1'b1, cap);
        check_frame($sformatf("v%0d_retry", i), cap, vecs[i].data, vecs[i].par);
        exp_nack = 1'b0;
      end
`endif
      wait_done(st, 200, $sformatf("v%0d", i));
      check($sformatf("v%0d_nack", i), nack_seen, exp_nack);
      check($sformatf("v%0d_timeout", i), to_seen, 1'b0);
      tick(2);
      check($sformatf("v%0d_ready_after", i), ready, 1'b1);
      check($sformatf("v%0d_oe_after", i), {clk_oe, data_oe}, 2'b00);
    end
    check("done_total", done_cnt, 5);

    st = done_cnt;
    request(8'h07);
    wait_done(st, 2 * (INH + STH + TOC + 100), "timeout");
    check("timeout_flag", to_seen, 1'b1);
    check("timeout_nack", nack_seen, 1'b0);
    tick(3);
    check("timeout_oe", {clk_oe, data_oe}, 2'b00);
    check("timeout_hold", timeout, 1'b1);

    st = done_cnt;
    request(8'hED);
    wait_host_release("abort");
    tick(20);
    for (int k = 0; k < 5; k++) begin
      dev_clk = 1'b0;
      tick(HALF);
      if (k < 4) begin
        dev_clk = 1'b1;
        tick(HALF);
      end
    end
    check("abort_bit4_driven", data_oe, 1'b1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("abort_oe_cleared", {clk_oe, data_oe}, 2'b00);
    @(negedge clk);
    rst = 1'b0;
    dev_clk = 1'b1;
    tick(100);
    check("abort_no_done", done_cnt, st);
    check("abort_ready", ready, 1'b1);

    st = done_cnt;
    request(8'h55);
    wait_host_release("v55");
    device_frame(1'b1, cap);
    check_frame("v55", cap, 8'h55, 1'b1);
    wait_done(st, 200, "v55");
    check("v55_nack", nack_seen, 1'b0);
    check("v55_timeout", to_seen, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
